ddram_burst_engine: RTL and testbench

Avalon-MM burst master that turns single-command, streamed-data transfer requests from core logic (memory tester, framebuffer writers) into legal Avalon bursts on one DDR port of the system memory block (ram1/ram2: 64-bit data, 29-bit word address, 8-bit burstcount). It sits directly upstream of the per-port safe terminator and drives its slave side. It handles one burst at a time and counts write beats and read data beats. The command side stays busy until the whole burst has completed.

---
 rtl/ddram_burst_engine_if.sv | 45 ++++
 rtl/ddram_burst_engine.sv | 141 ++++++++++++++
 tb/tb_ddram_burst_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddram_burst_engine_if.sv
// Command, streamed-data and Avalon-MM signals of one burst engine channel.
// master: the burst engine itself; slave: core logic plus the Avalon slave side.
interface ddram_burst_engine_if #(
  parameter int DW = 64,
  parameter int AW = 29,
  parameter int BW = 8
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic            cmd_write;
  logic [AW-1:0]   cmd_addr;
  logic [BW-1:0]   cmd_len;
  logic [DW-1:0]   wr_data;
  logic            wr_valid;
  logic            wr_ready;
  logic [DW-1:0]   rd_data;
  logic            rd_valid;
  logic            done;
  logic            busy;
  logic [AW-1:0]   avl_address;
  logic [BW-1:0]   avl_burstcount;
  logic            avl_read;
  logic            avl_write;
  logic [DW-1:0]   avl_writedata;
  logic [DW/8-1:0] avl_byteenable;
  logic            avl_waitrequest;
  logic [DW-1:0]   avl_readdata;
  logic            avl_readdatavalid;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           avl_waitrequest, avl_readdata, avl_readdatavalid,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           avl_address, avl_burstcount, avl_read, avl_write,
           avl_writedata, avl_byteenable
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid,
           avl_waitrequest, avl_readdata, avl_readdatavalid,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           avl_address, avl_burstcount, avl_read, avl_write,
           avl_writedata, avl_byteenable
  );
endinterface

// File: rtl/ddram_burst_engine.sv
// Avalon-MM burst master: one command becomes one burst on a DDR port;
// the command side stays busy until every beat of that burst has moved.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | cmd_ready high, waiting for a command
// S_WR      | write burst; avl_write follows wr_valid, one beat per accept
// S_RD_REQ  | avl_read held until the slave drops waitrequest
// S_RD_DATA | collecting read beats, then one settle cycle before DONE
// S_DONE    | done pulse, back to IDLE
module ddram_burst_engine #(
  parameter int DW = 64,
  parameter int AW = 29,
  parameter int BW = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ddram_burst_engine_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_REQ,
    S_RD_DATA,
    S_DONE
  } state_t;

  localparam logic [BW-1:0] CNT_ONE = BW'(1);

  state_t          r_state;
  logic            r_cmd_ready;
  logic            r_busy;
  logic            r_done;
  logic            r_rd_valid;
  logic            r_rd_last;
  logic            r_avl_read;
  logic [DW-1:0]   r_rd_data;
  logic [AW-1:0]   r_avl_address;
  logic [BW-1:0]   r_avl_burstcount;
  logic [BW-1:0]   r_cnt;

  logic            w_in_wr;
  logic            w_wr_beat;

  assign w_in_wr   = (r_state == S_WR);
  assign w_wr_beat = w_in_wr && io_bus.wr_valid && !io_bus.avl_waitrequest;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_cmd_ready      <= 1'b1;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_rd_valid       <= 1'b0;
      r_rd_last        <= 1'b0;
      r_avl_read       <= 1'b0;
      r_rd_data        <= '0;
      r_avl_address    <= '0;
      r_avl_burstcount <= '0;
      r_cnt            <= '0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.cmd_valid && r_cmd_ready) begin
            r_avl_address    <= io_bus.cmd_addr;
            r_avl_burstcount <= io_bus.cmd_len;
            r_cnt            <= io_bus.cmd_len;
            r_cmd_ready      <= 1'b0;
            r_busy           <= 1'b1;
            r_rd_last        <= 1'b0;
            if (io_bus.cmd_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (io_bus.cmd_write) begin
              r_state <= S_WR;
            end else begin
              r_state    <= S_RD_REQ;
              r_avl_read <= 1'b1;
            end
          end
        end
        S_WR: begin
          if (w_wr_beat) begin
            if (r_cnt == CNT_ONE) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
        end
        S_RD_REQ: begin
          if (!io_bus.avl_waitrequest) begin
            r_avl_read <= 1'b0;
            r_state    <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          // the cycle after the final beat presents it on rd_data, then DONE
          if (r_rd_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else if (io_bus.avl_readdatavalid) begin
            r_rd_data  <= io_bus.avl_readdata;
            r_rd_valid <= 1'b1;
            if (r_cnt == CNT_ONE) begin
              r_rd_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CNT_ONE;
            end
          end
        end
        S_DONE: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.cmd_ready      = r_cmd_ready;
  assign io_bus.busy           = r_busy;
  assign io_bus.done           = r_done;
  assign io_bus.rd_valid       = r_rd_valid;
  assign io_bus.rd_data        = r_rd_data;
  assign io_bus.avl_address    = r_avl_address;
  assign io_bus.avl_burstcount = r_avl_burstcount;
  assign io_bus.avl_read       = r_avl_read;
  assign io_bus.avl_write      = w_in_wr && io_bus.wr_valid;
  assign io_bus.wr_ready       = w_in_wr && !io_bus.avl_waitrequest;
  assign io_bus.avl_writedata  = io_bus.wr_data;
  assign io_bus.avl_byteenable = '1;

endmodule

// File: tb/tb_ddram_burst_engine.sv
// Directed bench for ddram_burst_engine: a table of burst commands plus
// hand sequences for back-to-back commands and reset in the middle of a read.
module tb_ddram_burst_engine;

  localparam logic [63:0] RD_BASE = 64'hDA7A_0000_0000_0000;

  typedef struct {
    bit          wr;
    logic [28:0] addr;
    logic [7:0]  len;
    int          lat;
    int          wait_rd;
    bit          toggle;
    int          gap_at;
    int          exp_lat;
    int          exp_rcyc;
    bit          hold;
    int          abort_at;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddram_burst_engine_if bus ();

  ddram_burst_engine dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bit          g_cmd_valid = 0;
  bit          g_wr = 0;
  logic [28:0] g_addr = '0;
  logic [7:0]  g_len = '0;
  int          g_lat = 1;
  bit          g_toggle = 0;
  bit          g_wr_src = 0;
  int          g_gap_at = -1;
  int          gap_left = 0;
  int          wait_left = 0;

  bit          acc = 0;
  int          t_acc = 0;
  int          wbeats = 0;
  int          rbeats = 0;
  int          rcyc = 0;
  int          err = 0;
  bit          got_done = 0;
  int          done_cyc = 0;
  int          last_done = 0;
  int          last_beat = 0;
  int          last_rdv = 0;
  int          n_done = 0;
  bit          prev_hold = 0;

  int          rd_next = 0;
  int          rd_left = 0;
  int          rd_idx = 0;
  bit          rd_live = 0;
  bit          prev_rdv = 0;
  logic [63:0] prev_data = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ctl"}, longint'({bus.cmd_ready, bus.busy, bus.done, bus.rd_valid,
                                 bus.avl_read, bus.avl_write, bus.wr_ready}),
        longint'(7'b1000000));
    chk({tag, ".addr"}, longint'(bus.avl_address), 0);
    chk({tag, ".bcount"}, longint'(bus.avl_burstcount), 0);
    chk({tag, ".rd_data"}, longint'(bus.rd_data), 0);
  endtask

  // one clock: drive core/slave inputs at the falling edge, then observe
  task automatic step();
    @(negedge clk);
    bus.cmd_valid = g_cmd_valid;
    bus.cmd_write = g_wr;
    bus.cmd_addr  = g_addr;
    bus.cmd_len   = g_len;
    if (bus.avl_read && wait_left > 0) begin
      bus.avl_waitrequest = 1'b1;
      wait_left--;
    end else begin
      bus.avl_waitrequest = g_toggle && acc && ((cyc - t_acc) % 2 == 0);
    end
    if (g_wr_src) begin
      if (g_gap_at >= 0 && wbeats == g_gap_at && gap_left > 0) begin
        bus.wr_valid = 1'b0;
        gap_left--;
      end else begin
        bus.wr_valid = 1'b1;
      end
    end else begin
      bus.wr_valid = 1'b0;
    end
    bus.wr_data = 64'(wbeats);
    if (rd_left > 0 && cyc >= rd_next) begin
      bus.avl_readdatavalid = 1'b1;
      bus.avl_readdata      = RD_BASE | 64'(rd_idx);
      rd_idx++;
      rd_left--;
      last_rdv = cyc;
    end else begin
      bus.avl_readdatavalid = 1'b0;
      bus.avl_readdata      = '0;
    end
    #1;
    if (bus.cmd_valid && bus.cmd_ready) begin
      acc   = 1;
      t_acc = cyc;
    end
    if (bus.rd_valid !== prev_rdv) err++;
    if (bus.rd_valid) begin
      rbeats++;
      if (bus.rd_data !== prev_data) err++;
    end
    prev_rdv  = bus.avl_readdatavalid && rd_live;
    prev_data = bus.avl_readdata;
    if (bus.avl_write) begin
      if (!bus.wr_valid) err++;
      if (bus.avl_address !== g_addr || bus.avl_burstcount !== g_len) err++;
      if (bus.wr_ready !== !bus.avl_waitrequest) err++;
      if (!bus.avl_waitrequest) begin
        if (bus.avl_writedata !== 64'(wbeats)) err++;
        wbeats++;
        last_beat = cyc;
      end
    end
    if (!bus.busy && bus.wr_ready) err++;
    if (bus.avl_read) begin
      rcyc++;
      if (bus.avl_address !== g_addr || bus.avl_burstcount !== g_len) err++;
      if (bus.avl_write) err++;
      if (!bus.avl_waitrequest) begin
        rd_next = cyc + g_lat;
        rd_left = int'(g_len);
        rd_idx  = 0;
        rd_live = 1;
      end
    end
    if (bus.cmd_ready && bus.busy) err++;
    if (bus.avl_byteenable !== 8'hFF) err++;
    if (bus.done) begin
      got_done = 1;
      done_cyc = cyc;
      n_done++;
    end
    cyc++;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int n;
    g_wr = v.wr; g_addr = v.addr; g_len = v.len; g_lat = v.lat;
    wait_left = v.wait_rd; g_toggle = v.toggle; g_gap_at = v.gap_at; gap_left = 3;
    g_wr_src = v.wr; g_cmd_valid = 1;
    acc = 0; wbeats = 0; rbeats = 0; rcyc = 0; err = 0; got_done = 0;
    n = 0;
    while (!acc && n < 50) begin step(); n++; end
    chk({tag, ".accepted"}, longint'(acc), 1);
    if (prev_hold) chk({tag, ".accept_cycle"}, t_acc - last_done, 1);
    if (!v.hold) g_cmd_valid = 0;
    if (v.abort_at > 0) begin
      n = 0;
      while (rbeats < v.abort_at && n < 100) begin step(); n++; end
      chk({tag, ".beats_before_reset"}, rbeats, v.abort_at);
      prev_hold = 0;
      return;
    end
    n = 0;
    while (!got_done && n < 400) begin step(); n++; end
    chk({tag, ".done_seen"}, longint'(got_done), 1);
    if (v.exp_lat >= 0) chk({tag, ".done_latency"}, done_cyc - t_acc, v.exp_lat);
    chk({tag, ".beats"}, v.wr ? wbeats : rbeats, int'(v.len));
    if (v.len != 0) begin
      if (v.wr) chk({tag, ".done_after_last_beat"}, done_cyc - last_beat, 1);
      else      chk({tag, ".done_after_last_rdv"}, done_cyc - last_rdv, 2);
    end
    chk({tag, ".read_cycles"}, rcyc, v.exp_rcyc);
    chk({tag, ".protocol_errors"}, err, 0);
    last_done = done_cyc;
    prev_hold = v.hold;
    if (!v.hold) begin
      step();
      chk({tag, ".ready_after_done"}, longint'(bus.cmd_ready), 1);
      chk({tag, ".no_extra_beats"}, v.wr ? wbeats : rbeats, int'(v.len));
    end
  endtask

  function automatic vec_t mk(bit wr, logic [28:0] a, logic [7:0] l, int lat, int w,
                              bit tg, int gap, int el, int er, bit hold, int ab);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.lat = lat; v.wait_rd = w; v.toggle = tg;
    v.gap_at = gap; v.exp_lat = el; v.exp_rcyc = er; v.hold = hold; v.abort_at = ab;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    int n;
    int d0;
    vecs[0] = mk(1, 29'h0001000,   8, 0, 0, 0, -1,   9, 0, 0, 0);
    vecs[1] = mk(1, 29'h0000200,   8, 0, 0, 1,  4,  18, 0, 0, 0);
    vecs[2] = mk(0, 29'h1ABCDEF,   4, 5, 2, 0, -1,  13, 3, 0, 0);
    vecs[3] = mk(1, 29'h0000040,   0, 0, 0, 0, -1,   1, 0, 0, 0);
    vecs[4] = mk(0, 29'h0000080,   0, 1, 0, 0, -1,   1, 0, 0, 0);
    vecs[5] = mk(0, 29'h1FFFFFFF,  1, 1, 0, 0, -1,   4, 1, 0, 0);
    vecs[6] = mk(1, 29'h0000000,   1, 0, 0, 0, -1,   2, 0, 0, 0);
    vecs[7] = mk(0, 29'h0000400, 128, 3, 0, 0, -1, 133, 1, 0, 0);

    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.wr_valid = 0; bus.avl_waitrequest = 0;
    bus.avl_readdata = '0; bus.avl_readdatavalid = 0;
    #1 rst = 1'b1;
    #1 chk_reset("reset");
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // back-to-back: cmd_valid never drops across three long bursts
    d0 = n_done;
    run_cmd(mk(0, 29'h0000100, 128, 2, 0, 0, -1, 132, 1, 1, 0), "b2b0");
    run_cmd(mk(1, 29'h0000200, 128, 0, 0, 0, -1, 129, 0, 1, 0), "b2b1");
    run_cmd(mk(0, 29'h0000300, 128, 2, 0, 0, -1, 132, 1, 0, 0), "b2b2");
    chk("b2b.done_pulses", n_done - d0, 3);

    // reset after two of eight read beats; the remaining beats still arrive
    d0 = n_done;
    run_cmd(mk(0, 29'h0000500, 8, 1, 0, 0, -1, -1, 1, 0, 2), "midrst");
    rst = 1'b1;
    #1 chk_reset("midrst.async");
    rd_live  = 0;
    prev_rdv = 0;
    step();
    step();
    rst = 1'b0;
    n = 0;
    while (rd_left > 0 && n < 20) begin step(); n++; end
    chk("midrst.drained", rd_left, 0);
    chk("midrst.rd_beats", rbeats, 2);
    chk("midrst.stray_errors", err, 0);
    chk("midrst.no_done", n_done - d0, 0);
    run_cmd(mk(1, 29'h0000600, 1, 0, 0, 0, -1, 2, 0, 0, 0), "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
